// File: rtl/dino_collide.sv
// dino_collide: per-frame dino/obstacle overlap test, idle/grace/run/dead sequencing and BCD score.
// Optional feature macro: DINO_HISCORE_EN adds a persistent o_hiscore output.
module dino_collide #(
   parameter  int unsigned N_OBS        = 2,
   parameter  int unsigned GRACE_FRAMES = 120,
   parameter  int unsigned HIT_FRAMES   = 2,
   parameter  int unsigned SCORE_DIV    = 6,
   localparam int unsigned IDX_W        = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ani_stb,
   input  logic                  i_start,
   input  logic [11:0]           i_dx1,
   input  logic [11:0]           i_dx2,
   input  logic [11:0]           i_dy1,
   input  logic [11:0]           i_dy2,
   input  logic [12*N_OBS-1:0]   i_ox1,
   input  logic [12*N_OBS-1:0]   i_ox2,
   input  logic [12*N_OBS-1:0]   i_oy1,
   input  logic [12*N_OBS-1:0]   i_oy2,
   output logic                  o_animate,
   output logic                  o_grace,
   output logic                  o_obs_rst,
   output logic                  o_game_over,
   output logic [15:0]           o_score,
   output logic [IDX_W-1:0]      o_hit_idx
`ifdef DINO_HISCORE_EN
  ,output logic [15:0]           o_hiscore
`endif
);

   localparam int unsigned GR_W = $clog2(GRACE_FRAMES + 2);
   localparam int unsigned HT_W = $clog2(HIT_FRAMES + 2);
   localparam int unsigned DV_W = $clog2(SCORE_DIV + 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRACE = 2'd1,
      ST_RUN   = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_start_q;
   logic              w_start_rise;
   logic [GR_W-1:0]   r_grace_cnt;
   logic [GR_W-1:0]   w_grace_cnt_nxt;
   logic [HT_W-1:0]   r_hit_cnt;
   logic [HT_W-1:0]   w_hit_cnt_nxt;
   logic [DV_W-1:0]   r_div_cnt;
   logic [DV_W-1:0]   w_div_cnt_nxt;
   logic [15:0]       r_score;
   logic [15:0]       w_score_nxt;
   logic [IDX_W-1:0]  r_hit_idx;
   logic [IDX_W-1:0]  w_hit_idx_nxt;
   logic              r_obs_rst;
   logic              w_obs_rst_nxt;
   logic              r_animate;
   logic              r_grace;
   logic              r_game_over;
   logic [N_OBS-1:0]  w_ovl;
   logic              w_any_ovl;
   logic [IDX_W-1:0]  w_low_idx;

   assign w_start_rise = i_start & ~r_start_q;

   // X edges are signed so obstacles scrolled past the left edge never alias; touching edges miss
   for (genvar k = 0; k < N_OBS; k++) begin : g_ovl
      assign w_ovl[k] = ($signed(i_dx1) < $signed(i_ox2[12*k +: 12])) &&
                        ($signed(i_ox1[12*k +: 12]) < $signed(i_dx2)) &&
                        (i_dy1 < i_oy2[12*k +: 12]) &&
                        (i_oy1[12*k +: 12] < i_dy2);
   end

   assign w_any_ovl = |w_ovl;

   // Lowest overlapping index wins
   always_comb begin
      w_low_idx = '0;
      for (int k = N_OBS - 1; k >= 0; k--) begin
         if (w_ovl[k]) w_low_idx = IDX_W'(k);
      end
   end

   // Packed BCD increment, saturating at 9999
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (v[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = v[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return (v == 16'h9999) ? v : r;
   endfunction

   always_comb begin
      w_state_nxt     = r_state;
      w_grace_cnt_nxt = r_grace_cnt;
      w_hit_cnt_nxt   = r_hit_cnt;
      w_div_cnt_nxt   = r_div_cnt;
      w_score_nxt     = r_score;
      w_hit_idx_nxt   = r_hit_idx;
      w_obs_rst_nxt   = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DEAD: begin
            // A restart takes precedence over any strobe in the same cycle
            if (w_start_rise) begin
               w_state_nxt     = ST_GRACE;
               w_obs_rst_nxt   = 1'b1;
               w_score_nxt     = '0;
               w_div_cnt_nxt   = '0;
               w_hit_cnt_nxt   = '0;
               w_grace_cnt_nxt = GR_W'(GRACE_FRAMES);
            end
         end
         ST_GRACE: begin
            if (i_ani_stb) begin
               if (r_grace_cnt <= GR_W'(1)) w_state_nxt = ST_RUN;
               else                         w_grace_cnt_nxt = r_grace_cnt - GR_W'(1);
            end
         end
         ST_RUN: begin
            if (i_ani_stb) begin
               if (w_any_ovl && (r_hit_cnt >= HT_W'(HIT_FRAMES - 1))) begin
                  w_state_nxt   = ST_DEAD;
                  w_hit_cnt_nxt = HT_W'(HIT_FRAMES);
                  w_hit_idx_nxt = w_low_idx;
               end else begin
                  w_hit_cnt_nxt = w_any_ovl ? (r_hit_cnt + HT_W'(1)) : '0;
                  if (r_div_cnt >= DV_W'(SCORE_DIV - 1)) begin
                     w_div_cnt_nxt = '0;
                     w_score_nxt   = bcd_inc(r_score);
                  end else begin
                     w_div_cnt_nxt = r_div_cnt + DV_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs register together with the state they decode so obstacles see reset and animate together
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_start_q   <= 1'b1;
         r_grace_cnt <= '0;
         r_hit_cnt   <= '0;
         r_div_cnt   <= '0;
         r_score     <= '0;
         r_hit_idx   <= '0;
         r_obs_rst   <= 1'b0;
         r_animate   <= 1'b0;
         r_grace     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_start_q   <= i_start;
         r_grace_cnt <= w_grace_cnt_nxt;
         r_hit_cnt   <= w_hit_cnt_nxt;
         r_div_cnt   <= w_div_cnt_nxt;
         r_score     <= w_score_nxt;
         r_hit_idx   <= w_hit_idx_nxt;
         r_obs_rst   <= w_obs_rst_nxt;
         r_animate   <= (w_state_nxt == ST_GRACE) || (w_state_nxt == ST_RUN);
         r_grace     <= (w_state_nxt == ST_GRACE);
         r_game_over <= (w_state_nxt == ST_DEAD);
      end
   end

   assign o_animate   = r_animate;
   assign o_grace     = r_grace;
   assign o_obs_rst   = r_obs_rst;
   assign o_game_over = r_game_over;
   assign o_score     = r_score;
   assign o_hit_idx   = r_hit_idx;

`ifdef DINO_HISCORE_EN
   logic [15:0] r_hiscore;

   // Valid BCD orders the same as unsigned, so a plain compare suffices
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hiscore <= '0;
      end else if ((w_state_nxt == ST_DEAD) && (r_state != ST_DEAD) && (r_score > r_hiscore)) begin
         r_hiscore <= r_score;
      end
   end

   assign o_hiscore = r_hiscore;
`endif

endmodule

// File: tb/tb_dino_collide.sv
// tb_dino_collide: directed and randomized stimulus for dino_collide, checked every cycle
// against an integer-level game model; DINO_HISCORE_EN also enables the high-score checks.
module tb_dino_collide;

   localparam int N_OBS        = 3;
   localparam int GRACE_FRAMES = 8;
   localparam int HIT_FRAMES   = 2;
   localparam int SCORE_DIV    = 3;
   localparam int IDX_W        = 2;

   localparam int M_IDLE  = 0;
   localparam int M_GRACE = 1;
   localparam int M_RUN   = 2;
   localparam int M_DEAD  = 3;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic                 i_ani_stb;
   logic                 i_start;
   logic [11:0]          i_dx1, i_dx2, i_dy1, i_dy2;
   logic [12*N_OBS-1:0]  i_ox1, i_ox2, i_oy1, i_oy2;
   logic                 o_animate, o_grace, o_obs_rst, o_game_over;
   logic [15:0]          o_score;
   logic [IDX_W-1:0]     o_hit_idx;
`ifdef DINO_HISCORE_EN
   logic [15:0]          o_hiscore;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model state: plain integers, decimal score
   int m_mode, m_grace_left, m_hits, m_div, m_score, m_hidx, m_hiscore;
   bit m_obs_rst, m_startq;

   dino_collide #(
      .N_OBS(N_OBS), .GRACE_FRAMES(GRACE_FRAMES), .HIT_FRAMES(HIT_FRAMES), .SCORE_DIV(SCORE_DIV)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_start(i_start),
      .i_dx1(i_dx1), .i_dx2(i_dx2), .i_dy1(i_dy1), .i_dy2(i_dy2),
      .i_ox1(i_ox1), .i_ox2(i_ox2), .i_oy1(i_oy1), .i_oy2(i_oy2),
      .o_animate(o_animate), .o_grace(o_grace), .o_obs_rst(o_obs_rst),
      .o_game_over(o_game_over), .o_score(o_score), .o_hit_idx(o_hit_idx)
`ifdef DINO_HISCORE_EN
     ,.o_hiscore(o_hiscore)
`endif
   );

   always #5 i_clk = ~i_clk;

   function automatic int sx(input logic [11:0] v);
      return int'($signed(v));
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Lowest overlapping obstacle, -1 when none
   function automatic int first_hit();
      int a1, a2, b1, b2;
      for (int k = 0; k < N_OBS; k++) begin
         a1 = sx(i_ox1[12*k +: 12]);
         a2 = sx(i_ox2[12*k +: 12]);
         b1 = int'(i_oy1[12*k +: 12]);
         b2 = int'(i_oy2[12*k +: 12]);
         if (sx(i_dx1) < a2 && a1 < sx(i_dx2) && int'(i_dy1) < b2 && b1 < int'(i_dy2))
            return k;
      end
      return -1;
   endfunction

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_mode = M_IDLE; m_grace_left = 0; m_hits = 0; m_div = 0;
         m_score = 0; m_hidx = 0; m_obs_rst = 1'b0; m_startq = 1'b1; m_hiscore = 0;
      end else begin
         bit rise;
         int h;
         rise      = i_start && !m_startq;
         m_startq  = i_start;
         m_obs_rst = 1'b0;
         h         = first_hit();
         case (m_mode)
            M_IDLE, M_DEAD: begin
               if (rise) begin
                  m_mode = M_GRACE; m_obs_rst = 1'b1; m_score = 0; m_div = 0;
                  m_hits = 0; m_grace_left = GRACE_FRAMES;
               end
            end
            M_GRACE: begin
               if (i_ani_stb) begin
                  if (m_grace_left <= 1) m_mode = M_RUN;
                  else m_grace_left--;
               end
            end
            M_RUN: begin
               if (i_ani_stb) begin
                  if (h >= 0) m_hits++; else m_hits = 0;
                  if (m_hits >= HIT_FRAMES) begin
                     m_mode = M_DEAD;
                     m_hidx = h;
                     if (m_score > m_hiscore) m_hiscore = m_score;
                  end else begin
                     m_div++;
                     if (m_div == SCORE_DIV) begin
                        m_div = 0;
                        if (m_score < 9999) m_score++;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      check("animate",   16'(o_animate),   16'(m_mode == M_GRACE || m_mode == M_RUN));
      check("grace",     16'(o_grace),     16'(m_mode == M_GRACE));
      check("game_over", 16'(o_game_over), 16'(m_mode == M_DEAD));
      check("obs_rst",   16'(o_obs_rst),   16'(m_obs_rst));
      check("score",     o_score,          to_bcd(m_score));
      check("hit_idx",   16'(o_hit_idx),   16'(m_hidx));
`ifdef DINO_HISCORE_EN
      check("hiscore",   o_hiscore,        to_bcd(m_hiscore));
`endif
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic strobes(input int n, input int gap);
      repeat (n) begin
         i_ani_stb = 1'b1;
         cyc(1);
         i_ani_stb = 1'b0;
         if (gap > 0) cyc(gap);
      end
   endtask

   task automatic set_obs(input int k, input int x1, input int x2, input int y1, input int y2);
      i_ox1[12*k +: 12] = 12'(x1);
      i_ox2[12*k +: 12] = 12'(x2);
      i_oy1[12*k +: 12] = 12'(y1);
      i_oy2[12*k +: 12] = 12'(y2);
   endtask

   task automatic clear_obs();
      for (int k = 0; k < N_OBS; k++) set_obs(k, 1000, 1040, 100, 140);
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      cyc(1);
      i_start = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b1; i_ani_stb = 1'b0;
      i_dx1 = 12'd20; i_dx2 = 12'd44; i_dy1 = 12'd100; i_dy2 = 12'd140;
      clear_obs();
      cyc(3);
      @(negedge i_clk);
      check("rst_score", o_score, 16'h0000);
      check("rst_grace", 16'(o_grace), 16'h0);
      check("rst_obs_rst", 16'(o_obs_rst), 16'h0);
      i_rst = 1'b0;
      cyc(3);
      @(negedge i_clk);
      check("held_start_no_go", 16'(o_animate), 16'h0);

      // Start: one-cycle obstacle reset together with GRACE entry
      i_start = 1'b0;
      cyc(1);
      start_pulse();
      @(negedge i_clk);
      check("start_obs_rst", 16'(o_obs_rst), 16'h1);
      check("start_grace", 16'(o_grace), 16'h1);
      cyc(1);
      @(negedge i_clk);
      check("obs_rst_one_cycle", 16'(o_obs_rst), 16'h0);
      strobes(GRACE_FRAMES - 2, 1);
      i_start = 1'b1;
      cyc(2);
      i_start = 1'b0;
      strobes(1, 0);
      @(negedge i_clk);
      check("grace_before_last", 16'(o_grace), 16'h1);
      strobes(1, 0);
      @(negedge i_clk);
      check("grace_done", 16'(o_grace), 16'h0);
      check("run_animate", 16'(o_animate), 16'h1);

      // Touching edges never hit; a real overlap on two strobes kills
      set_obs(0, 44, 68, 100, 140);
      strobes(10, 1);
      @(negedge i_clk);
      check("touch_alive", 16'(o_game_over), 16'h0);
      set_obs(0, 43, 67, 100, 140);
      set_obs(2, 30, 50, 110, 130);
      strobes(1, 0);
      @(negedge i_clk);
      check("one_hit_alive", 16'(o_game_over), 16'h0);
      strobes(1, 0);
      @(negedge i_clk);
      check("two_hits_dead", 16'(o_game_over), 16'h1);
      check("hit_idx0", 16'(o_hit_idx), 16'h0);
      check("score_frozen", o_score, 16'h0003);

      // Restart wins over a coincident strobe; grace ignores overlap
      clear_obs();
      i_start = 1'b1; i_ani_stb = 1'b1;
      cyc(1);
      i_ani_stb = 1'b0;
      @(negedge i_clk);
      check("restart_grace", 16'(o_grace), 16'h1);
      check("restart_score", o_score, 16'h0000);
      check("restart_obs_rst", 16'(o_obs_rst), 16'h1);
      i_start = 1'b0;
      set_obs(1, 30, 50, 110, 130);
      strobes(GRACE_FRAMES, 1);
      @(negedge i_clk);
      check("grace_overlap_ignored", 16'(o_game_over), 16'h0);
      set_obs(2, 30, 50, 110, 130);
      strobes(1, 0);
      @(negedge i_clk);
      check("first_run_strobe", 16'(o_game_over), 16'h0);
      strobes(1, 0);
      @(negedge i_clk);
      check("dead_idx1", 16'(o_hit_idx), 16'h1);

      // Signed X and alternating overlap; score carry
      clear_obs();
      start_pulse();
      strobes(GRACE_FRAMES, 0);
      set_obs(0, -30, -6, 100, 140);
      strobes(5, 0);
      for (int i = 0; i < 20; i++) begin
         set_obs(0, 30, 50, 100, 140);
         strobes(1, 0);
         set_obs(0, -30, -6, 100, 140);
         strobes(1, 0);
      end
      @(negedge i_clk);
      check("alternate_alive", 16'(o_game_over), 16'h0);
      check("score_15", o_score, 16'h0015);
      strobes(15, 0);
      @(negedge i_clk);
      check("score_20", o_score, 16'h0020);

      // Reset mid-RUN clears asynchronously without an obstacle reset pulse
      i_rst = 1'b1;
      #1;
      check("async_rst_score", o_score, 16'h0000);
      check("async_rst_animate", 16'(o_animate), 16'h0);
      check("async_rst_obs_rst", 16'(o_obs_rst), 16'h0);
      cyc(1);
      i_rst = 1'b0;
      cyc(2);

`ifdef DINO_HISCORE_EN
      start_pulse();
      strobes(GRACE_FRAMES, 0);
      strobes(125, 0);
      set_obs(0, 30, 50, 100, 140);
      strobes(2, 0);
      @(negedge i_clk);
      check("hs_score42", o_score, 16'h0042);
      check("hs_42", o_hiscore, 16'h0042);
      clear_obs();
      start_pulse();
      strobes(GRACE_FRAMES, 0);
      strobes(50, 0);
      set_obs(0, 30, 50, 100, 140);
      strobes(2, 0);
      @(negedge i_clk);
      check("hs_score17", o_score, 16'h0017);
      check("hs_keep42", o_hiscore, 16'h0042);
      i_rst = 1'b1;
      #1;
      check("hs_rst", o_hiscore, 16'h0000);
      cyc(1);
      i_rst = 1'b0;
      clear_obs();
      cyc(2);
`endif

      // Randomized play
      for (int c = 0; c < 4000; c++) begin
         i_ani_stb = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) i_start = ~i_start;
         if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < N_OBS; k++) begin
               int x1, y1;
               x1 = int'($urandom_range(0, 200)) - 80;
               y1 = int'($urandom_range(60, 150));
               set_obs(k, x1, x1 + int'($urandom_range(1, 30)), y1, y1 + int'($urandom_range(1, 30)));
            end
         end
         i_rst = ($urandom_range(0, 1999) == 0);
         cyc(1);
      end
      i_rst = 1'b0; i_ani_stb = 1'b0; i_start = 1'b0;

      // Long run to BCD saturation
      clear_obs();
      i_rst = 1'b1;
      cyc(1);
      i_rst = 1'b0;
      cyc(2);
      start_pulse();
      strobes(GRACE_FRAMES, 0);
      i_ani_stb = 1'b1;
      cyc(29994);
      i_ani_stb = 1'b0;
      @(negedge i_clk);
      check("score_9998", o_score, 16'h9998);
      i_ani_stb = 1'b1;
      cyc(18);
      i_ani_stb = 1'b0;
      @(negedge i_clk);
      check("score_sat", o_score, 16'h9999);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
